// File: rtl/bus_arbiter.sv
// Arbitrates the pipeline's data and instruction-fetch ports onto one shared memory bus.
// Data has fixed priority; each access completes on bus_ack_i or is abandoned after TIMEOUT cycles.
module bus_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   input  logic        d_ce_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_sel_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic [31:0] d_rdata_o,
   output logic        stallreq_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        d_done_q, d_done_d;
   logic        i_done_q, i_done_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [3:0]  bus_sel_q, bus_sel_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        bus_err_q, bus_err_d;
   logic        stall;

   assign stall = (d_ce_i & ~d_done_q) | (if_ce_i & ~i_done_q);

   always_comb begin
      state_d     = state_q;
      d_done_d    = d_done_q;
      i_done_d    = i_done_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_data_d   = if_data_q;
      d_rdata_d   = d_rdata_q;
      bus_err_d   = 1'b0;

      // Pipeline advancing starts a fresh request set; a completion below still wins.
      if (!stall) begin
         d_done_d = 1'b0;
         i_done_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (d_ce_i && !d_done_q) begin
               bus_we_d    = d_we_i;
               bus_sel_d   = d_sel_i;
               bus_addr_d  = d_addr_i;
               bus_wdata_d = d_wdata_i;
               bus_req_d   = 1'b1;
               cnt_d       = 8'd0;
               state_d     = BUSY_D;
            end else if (if_ce_i && !i_done_q) begin
               bus_we_d    = 1'b0;
               bus_sel_d   = 4'b1111;
               bus_addr_d  = if_addr_i;
               bus_req_d   = 1'b1;
               cnt_d       = 8'd0;
               state_d     = BUSY_I;
            end
         end
         BUSY_D, BUSY_I: begin
            if (bus_ack_i) begin
               if (state_q == BUSY_D) begin
                  d_done_d = 1'b1;
                  if (!bus_we_q) d_rdata_d = bus_rdata_i;
               end else begin
                  i_done_d  = 1'b1;
                  if_data_d = bus_rdata_i;
               end
               bus_req_d = 1'b0;
               cnt_d     = 8'd0;
               state_d   = IDLE;
            end else if (cnt_q == LAST_CNT) begin
               // Abandoned access: report it and hand the consumer a zero word.
               if (state_q == BUSY_D) begin
                  d_done_d  = 1'b1;
                  d_rdata_d = 32'd0;
               end else begin
                  i_done_d  = 1'b1;
                  if_data_d = 32'd0;
               end
               bus_err_d = 1'b1;
               bus_req_d = 1'b0;
               cnt_d     = 8'd0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         d_done_q    <= 1'b0;
         i_done_q    <= 1'b0;
         cnt_q       <= 8'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= 4'd0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         if_data_q   <= 32'd0;
         d_rdata_q   <= 32'd0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_done_q    <= d_done_d;
         i_done_q    <= i_done_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_data_q   <= if_data_d;
         d_rdata_q   <= d_rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign stallreq_o  = stall;
   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_sel_o   = bus_sel_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign if_data_o   = if_data_q;
   assign d_rdata_o   = d_rdata_q;
   assign bus_err_o   = bus_err_q;

endmodule
